// File: rtl/apu_length_counter_bank.sv
// Multi-channel APU length-counter bank: per-channel down-counters loaded from
// the 32-entry length table, decremented on frame-counter half-frame pulses.
module apu_length_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int HW_QUIRKS = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       en_in,
  input  logic [NUM_CH-1:0]       halt_in,
  input  logic                    length_pulse_in,
  input  logic [NUM_CH-1:0]       length_wr_in,
  input  logic [NUM_CH*5-1:0]     length_in,
  output logic [NUM_CH-1:0]       en_out,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       expire_out
);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
  logic [NUM_CH-1:0] halt_q;
  logic [NUM_CH-1:0] expire_q;
  logic [NUM_CH-1:0] expire_nxt;
  logic [NUM_CH-1:0] halt_eff;
  logic [NUM_CH-1:0] can_dec;

  function automatic logic [CNT_W-1:0] length_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'h00: v = 8'h0A; 5'h01: v = 8'hFE; 5'h02: v = 8'h14; 5'h03: v = 8'h02;
      5'h04: v = 8'h28; 5'h05: v = 8'h04; 5'h06: v = 8'h50; 5'h07: v = 8'h06;
      5'h08: v = 8'hA0; 5'h09: v = 8'h08; 5'h0A: v = 8'h3C; 5'h0B: v = 8'h0A;
      5'h0C: v = 8'h0E; 5'h0D: v = 8'h0C; 5'h0E: v = 8'h1A; 5'h0F: v = 8'h0E;
      5'h10: v = 8'h0C; 5'h11: v = 8'h10; 5'h12: v = 8'h18; 5'h13: v = 8'h12;
      5'h14: v = 8'h30; 5'h15: v = 8'h14; 5'h16: v = 8'h60; 5'h17: v = 8'h16;
      5'h18: v = 8'hC0; 5'h19: v = 8'h18; 5'h1A: v = 8'h48; 5'h1B: v = 8'h1A;
      5'h1C: v = 8'h10; 5'h1D: v = 8'h1C; 5'h1E: v = 8'h20; default: v = 8'h1E;
    endcase
    return CNT_W'(v);
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_nxt[c]    = cnt[c];
      expire_nxt[c] = 1'b0;
      halt_eff[c]   = (HW_QUIRKS != 0) ? halt_q[c] : halt_in[c];
      can_dec[c]    = length_pulse_in && !halt_eff[c] && (cnt[c] != '0);
      if (!en_in[c]) begin
        cnt_nxt[c] = '0;
      end else if (length_wr_in[c] && length_pulse_in) begin
        // 2A03 race: a write landing on a clocked, non-zero counter is lost
        if ((HW_QUIRKS != 0) && (cnt[c] != '0)) begin
          if (can_dec[c]) begin
            cnt_nxt[c]    = cnt[c] - 1'b1;
            expire_nxt[c] = (cnt[c] == CNT_W'(1));
          end
        end else begin
          cnt_nxt[c] = length_lut(length_in[5*c +: 5]);
        end
      end else if (length_wr_in[c]) begin
        cnt_nxt[c] = length_lut(length_in[5*c +: 5]);
      end else if (can_dec[c]) begin
        cnt_nxt[c]    = cnt[c] - 1'b1;
        expire_nxt[c] = (cnt[c] == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      halt_q   <= '0;
      expire_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= cnt_nxt[c];
      halt_q   <= halt_in;
      expire_q <= expire_nxt;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign count_out[CNT_W*g +: CNT_W] = cnt[g];
    assign en_out[g]                   = (cnt[g] != '0);
  end
  assign expire_out = expire_q;

endmodule

// File: tb/tb_apu_length_counter_bank.sv
// Bench for apu_length_counter_bank: a quirk-mode and an idealised instance share
// stimulus; a table-driven reference model predicts every channel of both.
module tb_apu_length_counter_bank;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en, halt, wr;
  logic           pulse;
  logic [NCH*5-1:0] idx;
  logic [NCH-1:0]   en_q, en_i, exp_q, exp_i;
  logic [NCH*8-1:0] cnt_q, cnt_i;

  int checks = 0;
  int errors = 0;

  int lut [32] = '{8'h0A, 8'hFE, 8'h14, 8'h02, 8'h28, 8'h04, 8'h50, 8'h06,
                   8'hA0, 8'h08, 8'h3C, 8'h0A, 8'h0E, 8'h0C, 8'h1A, 8'h0E,
                   8'h0C, 8'h10, 8'h18, 8'h12, 8'h30, 8'h14, 8'h60, 8'h16,
                   8'hC0, 8'h18, 8'h48, 8'h1A, 8'h10, 8'h1C, 8'h20, 8'h1E};

  // model state: index 1 = quirk instance, index 0 = idealised instance
  int m_cnt [2][NCH];
  int m_exp [2][NCH];
  int m_hq  [NCH];

  always #5 clk = ~clk;

  apu_length_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .HW_QUIRKS(1)) dut_q (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .halt_in(halt),
    .length_pulse_in(pulse), .length_wr_in(wr), .length_in(idx),
    .en_out(en_q), .count_out(cnt_q), .expire_out(exp_q));

  apu_length_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .HW_QUIRKS(0)) dut_i (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .halt_in(halt),
    .length_pulse_in(pulse), .length_wr_in(wr), .length_in(idx),
    .en_out(en_i), .count_out(cnt_i), .expire_out(exp_i));

  function automatic logic [31:0] obs_cnt(int q, int c);
    return q ? 32'(cnt_q[8*c +: 8]) : 32'(cnt_i[8*c +: 8]);
  endfunction
  function automatic logic [31:0] obs_en(int q, int c);
    return q ? 32'(en_q[c]) : 32'(en_i[c]);
  endfunction
  function automatic logic [31:0] obs_exp(int q, int c);
    return q ? 32'(exp_q[c]) : 32'(exp_i[c]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_model();
    for (int q = 0; q < 2; q++)
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("cnt q%0d ch%0d", q, c), obs_cnt(q, c), 32'(m_cnt[q][c]));
        chk($sformatf("en q%0d ch%0d", q, c), obs_en(q, c), 32'(m_cnt[q][c] != 0));
        chk($sformatf("exp q%0d ch%0d", q, c), obs_exp(q, c), 32'(m_exp[q][c]));
      end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 2; q++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[q][c] = 0;
        m_exp[q][c] = 0;
      end
    for (int c = 0; c < NCH; c++) m_hq[c] = 0;
  endtask

  // One clock: predict from the applied inputs, wait for the edge, then compare.
  task automatic step();
    int nc [2][NCH];
    int ne [2][NCH];
    for (int q = 0; q < 2; q++)
      for (int c = 0; c < NCH; c++) begin
        int  cur = m_cnt[q][c];
        bit  hlt = q ? (m_hq[c] != 0) : halt[c];
        bit  clocked = pulse && !hlt && cur > 0;
        int  loaded = lut[idx[5*c +: 5]];
        nc[q][c] = cur;
        ne[q][c] = 0;
        if (!en[c]) nc[q][c] = 0;
        else if (wr[c] && pulse && q == 1 && cur > 0) begin
          if (clocked) begin nc[q][c] = cur - 1; ne[q][c] = (cur == 1); end
        end else if (wr[c]) nc[q][c] = loaded;
        else if (clocked) begin nc[q][c] = cur - 1; ne[q][c] = (cur == 1); end
      end
    @(posedge clk);
    m_cnt = nc;
    m_exp = ne;
    for (int c = 0; c < NCH; c++) m_hq[c] = halt[c];
    #1;
    check_model();
    wr    = '0;
    pulse = 1'b0;
  endtask

  task automatic load(input int c, input int i);
    wr[c] = 1'b1;
    idx[5*c +: 5] = 5'(i);
    step();
  endtask

  task automatic pulse_step();
    pulse = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; en = '1; halt = '0; wr = '0; pulse = 1'b0; idx = '0;
    model_reset();
    #12;
    chk("reset_cnt_q", 32'(cnt_q), 32'h0);
    chk("reset_cnt_i", 32'(cnt_i), 32'h0);
    chk("reset_exp", 32'({exp_q, exp_i, en_q, en_i}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // load
    load(0, 1);
    chk("load_fe", obs_cnt(1, 0), 32'hFE);
    chk("load_en", obs_en(0, 0), 32'h1);
    chk("load_others", obs_cnt(1, 1) | obs_cnt(1, 2) | obs_cnt(1, 3), 32'h0);

    // countdown and expiry
    load(0, 3);
    pulse_step();
    chk("cd_1", obs_cnt(1, 0), 32'h1);
    pulse_step();
    chk("cd_0", obs_cnt(0, 0), 32'h0);
    chk("cd_expire", obs_exp(1, 0), 32'h1);
    chk("cd_en_fall", obs_en(1, 0), 32'h0);
    step();
    chk("cd_expire_once", obs_exp(1, 0), 32'h0);
    pulse_step();
    chk("cd_sat", obs_cnt(1, 0), 32'h0);
    chk("cd_no_expire", obs_exp(0, 0), 32'h0);

    // halt timing: load 6, clock to 5, then raise halt with a pulse
    load(0, 7);
    pulse_step();
    halt[0] = 1'b1;
    pulse_step();
    chk("halt_quirk_same", obs_cnt(1, 0), 32'h4);
    chk("halt_ideal_same", obs_cnt(0, 0), 32'h5);
    pulse_step();
    chk("halt_quirk_next", obs_cnt(1, 0), 32'h4);
    halt[0] = 1'b0;
    step();

    // write/pulse race
    load(0, 0);
    wr[0] = 1'b1; idx[4:0] = 5'h08;
    pulse_step();
    chk("race_quirk_drop", obs_cnt(1, 0), 32'h09);
    chk("race_ideal_load", obs_cnt(0, 0), 32'hA0);
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    wr[0] = 1'b1; idx[4:0] = 5'h08;
    pulse_step();
    chk("race_quirk_zero", obs_cnt(1, 0), 32'hA0);

    // enable clear
    load(0, 5'h14);
    chk("en_pre", obs_cnt(1, 0), 32'h30);
    en[0] = 1'b0;
    step();
    chk("en_clear", obs_cnt(1, 0), 32'h0);
    chk("en_clear_noexp", obs_exp(1, 0), 32'h0);
    load(0, 1);
    chk("en_wr_ignored", obs_cnt(0, 0), 32'h0);
    en[0] = 1'b1;

    // asynchronous reset mid-count
    wr = '1; idx = {5'h01, 5'h08, 5'h18, 5'h16};
    step();
    pulse_step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt_q) | 32'(cnt_i), 32'h0);
    chk("async_en", 32'({en_q, en_i}), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    pulse_step();
    chk("after_reset_hold", obs_cnt(1, 3), 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        en[c]   = ($urandom_range(0, 9) != 0);
        halt[c] = ($urandom_range(0, 3) == 0);
        wr[c]   = ($urandom_range(0, 5) == 0);
        idx[5*c +: 5] = 5'($urandom_range(0, 31));
      end
      pulse = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apu_length_counter_bank.md
Name: apu_length_counter_bank

Overview:
- Multi-channel, parametrised length-counter bank for the APU. Replaces the per-channel single length counters with one block serving all channels.
- Each channel keeps a down-counter that is loaded from the standard 32-entry length table and decremented on frame-counter length pulses.
- Each channel reports non-zero status, its current count and a one-cycle expiry pulse.
- An optional hardware-quirk mode reproduces the 2A03 write/clock race and delayed-halt behaviour.

Parameters:
- NUM_CH, 4, number of independent channels (1..8).
- CNT_W, 8, counter width in bits (>= 8); table values are zero-extended to CNT_W.
- HW_QUIRKS, 1, 1 = 2A03 race/halt-delay emulation; 0 = idealised behaviour.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- en_in  input  NUM_CH  per-channel enable from $4015; low forces the counter to 0.
- halt_in  input  NUM_CH  per-channel halt (envelope loop flag); high stops decrement.
- length_pulse_in  input  1  shared half-frame length pulse from the frame counter; 1 cycle wide.
- length_wr_in  input  NUM_CH  per-channel load strobe.
- length_in  input  NUM_CH*5  per-channel 5-bit table index; channel c uses bits [5c+4:5c].
- en_out  output  NUM_CH  channel counter is non-zero.
- count_out  output  NUM_CH*CNT_W  current counters; channel c uses bits [CNT_W*c+CNT_W-1 : CNT_W*c].
- expire_out  output  NUM_CH  one-cycle pulse when a counter reaches 0 by decrement.

Behaviour:
- Reset: while rst_n_in = 0, asynchronously clear all counters, halt_q and expire_out. en_out = 0, count_out = 0, expire_out = 0.
- Per channel, the registered state is cnt[CNT_W], halt_q[1] and expire_q[1]. All channels update in parallel on the same clock edge.
- Length table, index 0x00..0x1F, values in hex:
  - 0A FE 14 02 28 04 50 06
  - A0 08 3C 0A 0E 0C 1A 0E
  - 0C 10 18 12 30 14 60 16
  - C0 18 48 1A 10 1C 20 1E
- Effective halt: halt_eff = halt_q when HW_QUIRKS = 1; halt_eff = halt_in when HW_QUIRKS = 0.
  - halt_q <= halt_in every cycle, so with quirks a halt change affects pulses from the next cycle on.
- Next-state priority per channel, evaluated each cycle:
  1. en_in = 0: cnt <= 0. Any write is ignored. No expire pulse.
  2. Write and pulse in the same cycle (length_wr_in = 1 and length_pulse_in = 1):
     - HW_QUIRKS = 1 and cnt != 0: the write is dropped. Decrement as in step 4 if halt_eff = 0, otherwise hold.
     - HW_QUIRKS = 1 and cnt == 0: load the table value; no decrement this cycle.
     - HW_QUIRKS = 0: load the table value; the pulse is ignored for this channel.
  3. Write alone (length_wr_in = 1): cnt <= table[idx].
  4. Decrement: length_pulse_in = 1, halt_eff = 0 and cnt != 0 gives cnt <= cnt - 1.
  5. Otherwise: hold.
- No wrap-around: the counter saturates at 0, and a pulse at 0 leaves it at 0.
- expire_out:
  - Registered. Set for exactly one cycle, the cycle after a decrement moved cnt from 1 to 0.
  - Not asserted when the counter is cleared by en_in = 0, and not asserted at reset.
- en_out = (cnt != 0), combinational from the register; it follows the load by 1 cycle.
- count_out is driven directly from the registers.
- A reset asserted mid-count clears immediately; the counter resumes only on a new write after release.

Test Plan:
1. Load: en = 1, write idx 0x01 on ch0 → count_out[ch0] = 0xFE and en_out[0] = 1 the next cycle. Other channels stay 0.
2. Countdown and expire: load idx 0x03 (value 2), then issue two pulses with halt = 0 → count goes 2 → 1 → 0. expire_out[0] pulses 1 cycle after the second pulse, and en_out[0] falls. A third pulse leaves the count at 0 with no expire.
3. Halt with quirk: count = 5 and HW_QUIRKS = 1; raise halt_in and pulse in the same cycle → count = 4. A pulse on the next cycle → count stays 4. With HW_QUIRKS = 0 the same-cycle pulse leaves the count at 5.
4. Write/pulse race with HW_QUIRKS = 1:
   - count = 0x0A, write idx 0x08 together with a pulse → count = 0x09 (write dropped).
   - count = 0, same stimulus → count = 0xA0.
   - With HW_QUIRKS = 0, the count = 0x0A case → count = 0xA0.
5. Enable clear: count = 0x30 and en_in drops → count = 0 the next cycle, no expire_out. A write while en_in = 0 is ignored.
6. Async reset: with four channels counting, drop rst_n_in between clock edges → all outputs are 0 immediately, before the next clock edge.
